// File: rtl/expand_pcm_pkg.sv
// Shared constants and types for the G.711 PCM-to-linear expander.
package expand_pcm_pkg;

    typedef logic [7:0]  pcm_t;
    typedef logic [13:0] lin_t;

    localparam logic LAW_ALAW = 1'b1;
    localparam logic LAW_ULAW = 1'b0;

    localparam lin_t ULAW_BIAS = 14'd33;
    localparam pcm_t ALAW_XOR  = 8'h55;

endpackage

// File: rtl/expand_pcm_g711_decode.sv
// Combinational G.711 decode: code word + law select to sign and 13-bit scaled magnitude.
module expand_pcm_g711_decode
    import expand_pcm_pkg::*;
(
    input  pcm_t        code,
    input  logic        law,
    output logic        sss,
    output logic [12:0] ssq
);

    pcm_t       c;
    logic [2:0] e;
    logic [3:0] m;
    lin_t       base;
    lin_t       mag;

    always_comb begin
        c    = (law == LAW_ALAW) ? (code ^ ALAW_XOR) : ~code;
        e    = c[6:4];
        m    = c[3:0];
        // 2m + 33, the biased segment value shared by both laws
        base = {9'd0, m, 1'b0} + ULAW_BIAS;
        sss  = 1'b0;
        mag  = '0;
        if (law == LAW_ALAW) begin
            sss = ~c[7];
            if (e == 3'd0) begin
                mag = {9'd0, m, 1'b1};
            end else begin
                mag = base << (e - 3'd1);
            end
            // A-law magnitude is one bit short of the u-law scale
            mag = mag << 1;
        end else begin
            sss = c[7];
            mag = (base << e) - ULAW_BIAS;
        end
    end

    assign ssq = mag[12:0];

    logic unused_mag_msb;
    assign unused_mag_msb = mag[13];

endmodule

// File: rtl/expand_pcm.sv
// G.711 PCM-to-linear expander with registered 14-bit output.
// Optional EXPAND_VALID_EN adds in_valid/out_valid qualification.
module expand_pcm
    import expand_pcm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
`ifdef EXPAND_VALID_EN
    input  logic        in_valid,
    output logic        out_valid,
`endif
    input  logic [13:0] SIN,
    input  logic        LAW,
    output logic [13:0] SOUT
);

    logic        sss;
    logic [12:0] ssq;
    lin_t        sl;
    lin_t        sout_d;
    lin_t        sout_q;

    expand_pcm_g711_decode u_decode (
        .code (SIN[7:0]),
        .law  (LAW),
        .sss  (sss),
        .ssq  (ssq)
    );

    // Two's-complement negate; a zero magnitude stays zero, so negative zero maps to 0
    assign sl = sss ? (14'd0 - {1'b0, ssq}) : {1'b0, ssq};

`ifdef EXPAND_VALID_EN
    logic out_valid_q;

    always_comb begin
        sout_d = sout_q;
        if (in_valid) begin
            sout_d = sl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
        end
    end

    assign out_valid = out_valid_q;
`else
    always_comb begin
        sout_d = sl;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sout_q <= '0;
        end else begin
            sout_q <= sout_d;
        end
    end

    assign SOUT = sout_q;

    logic unused_sin_hi;
    assign unused_sin_hi = ^SIN[13:8];

endmodule

// File: tb/tb_expand_pcm.sv
// Self-checking bench for expand_pcm: directed G.711 vectors plus a short random stream.
module tb_expand_pcm;

    logic        clk;
    logic        reset;
    logic [13:0] SIN;
    logic        LAW;
    logic [13:0] SOUT;
`ifdef EXPAND_VALID_EN
    logic        in_valid;
    logic        out_valid;
`endif

    int n_checks;
    int n_fail;

    expand_pcm dut (
        .clk       (clk),
        .reset     (reset),
`ifdef EXPAND_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .SIN       (SIN),
        .LAW       (LAW),
        .SOUT      (SOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 14'h%04h expected 14'h%04h", tag, got, exp);
        end
    endtask

    // Independent integer reference of the G.711 expansion
    function automatic logic [13:0] model(input logic [7:0] code, input logic law);
        int  c;
        int  e;
        int  m;
        int  mag;
        bit  neg;
        if (law) begin
            c   = int'(code ^ 8'h55);
            neg = ((c >> 7) & 1) == 0;
            e   = (c >> 4) & 7;
            m   = c & 15;
            mag = (e == 0) ? (2 * m + 1) : ((2 * m + 33) * (1 << (e - 1)));
            mag = mag * 2;
        end else begin
            c   = int'(~code);
            neg = ((c >> 7) & 1) == 1;
            e   = (c >> 4) & 7;
            m   = c & 15;
            mag = (2 * m + 33) * (1 << e) - 33;
        end
        return neg ? 14'(-mag) : 14'(mag);
    endfunction

    // Apply one code, clock it in, check just after the edge
    task automatic apply(input string tag, input logic [7:0] code, input logic law,
                         input logic [13:0] exp);
        SIN = {6'h2A, code};
        LAW = law;
        @(posedge clk);
        #1;
        check(tag, SOUT, exp);
    endtask

    logic [7:0]  r_code;
    logic [5:0]  r_hi;
    logic [13:0] r_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        SIN      = 14'h0080;
        LAW      = 1'b0;
`ifdef EXPAND_VALID_EN
        in_valid = 1'b1;
`endif
        reset    = 1'b0;
        #1;
        reset    = 1'b1;
        #1;
        check("reset_initial", SOUT, 14'h0000);
        @(posedge clk);
        #1;
        check("reset_held_edge", SOUT, 14'h0000);
        #2;
        reset = 1'b0;

        // u-law directed
        apply("ulaw_ff",  8'hFF, 1'b0, 14'h0000);
        apply("ulaw_7f_negzero", 8'h7F, 1'b0, 14'h0000);
        apply("ulaw_80",  8'h80, 1'b0, 14'h1F5F);
        apply("ulaw_00",  8'h00, 1'b0, 14'h20A1);
        apply("ulaw_ef",  8'hEF, 1'b0, 14'h0021);

        // A-law directed
        apply("alaw_d5",  8'hD5, 1'b1, 14'h0002);
        apply("alaw_55",  8'h55, 1'b1, 14'h3FFE);
        apply("alaw_aa",  8'hAA, 1'b1, 14'h1F80);
        apply("alaw_2a",  8'h2A, 1'b1, 14'h2080);

        // Asynchronous reset mid-stream
        apply("pre_reset", 8'h80, 1'b0, 14'h1F5F);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", SOUT, 14'h0000);
        @(posedge clk);
        #1;
        check("reset_hold", SOUT, 14'h0000);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", SOUT, 14'h1F5F);

        // Random stream, LAW toggling each cycle; output must hold mid-cycle
        LAW = 1'b0;
        for (int i = 0; i < 10; i++) begin
            r_code = 8'($urandom_range(0, 255));
            r_hi   = 6'($urandom_range(0, 63));
            SIN    = {r_hi, r_code};
            LAW    = ~LAW;
            r_exp  = model(r_code, LAW);
            @(posedge clk);
            #1;
            check($sformatf("stream_%0d", i), SOUT, r_exp);
            SIN = {~r_hi, ~r_code};
            #3;
            check($sformatf("stream_hold_%0d", i), SOUT, r_exp);
        end

`ifdef EXPAND_VALID_EN
        apply("v_prime", 8'h80, 1'b0, 14'h1F5F);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SIN = {6'd0, 8'(i * 37 + 5)};
            LAW = i[0];
            @(posedge clk);
            #1;
            check($sformatf("v_hold_%0d", i), SOUT, 14'h1F5F);
            check($sformatf("v_outvalid_lo_%0d", i), {13'd0, out_valid}, 14'd0);
        end
        in_valid = 1'b1;
        apply("v_alaw_aa", 8'hAA, 1'b1, 14'h1F80);
        check("v_outvalid_hi", {13'd0, out_valid}, 14'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
